// File: rtl/axi_ram_responder.sv
// AXI3 slave backed by a byte-strobed synchronous RAM; one burst outstanding per direction.
// Optional AXI_RAM_RESPONDER_RANGE_CHECK_EN: bursts starting above the RAM range respond 2'b11.
module axi_ram_responder #(
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned MEM_ADDR_WIDTH = 10
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // Write address
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [31:0]                 s_axi_awaddr,
    input  logic [3:0]                  s_axi_awlen,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    // Write data
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    // Write response
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    // Read address
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [31:0]                 s_axi_araddr,
    input  logic [3:0]                  s_axi_arlen,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    // Read data
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int unsigned NumBytes = AXI_DATA_WIDTH / 8;
    localparam int unsigned ByteLsb  = $clog2(NumBytes);
    localparam int unsigned AddrTop  = MEM_ADDR_WIDTH + ByteLsb;
    localparam int unsigned Depth    = 2 ** MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic [1:0] {RIdle, RFetch, RData} rstate_e;

    logic [AXI_DATA_WIDTH-1:0] mem_q [Depth];

    wstate_e                   wstate_q, wstate_d;
    logic [AXI_ID_WIDTH-1:0]   wid_q, wid_d;
    logic [MEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]                wlen_q, wlen_d;
    logic [3:0]                wcnt_q, wcnt_d;
    logic                      werr_q, werr_d;
    logic                      mem_we;

    rstate_e                   rstate_q, rstate_d;
    logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [MEM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [3:0]                rlen_q, rlen_d;
    logic [3:0]                rcnt_q, rcnt_d;
    logic                      rerr_q, rerr_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic aw_oor, ar_oor;
    // Only the word-index slice of the addresses is decoded; the rest is intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

`ifdef AXI_RAM_RESPONDER_RANGE_CHECK_EN
    assign aw_oor = |(s_axi_awaddr >> AddrTop);
    assign ar_oor = |(s_axi_araddr >> AddrTop);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ---------------- Write channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= WIdle;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
        end
    end

    always_comb begin
        wstate_d      = wstate_q;
        wid_d         = wid_q;
        waddr_d       = waddr_q;
        wlen_d        = wlen_q;
        wcnt_d        = wcnt_q;
        werr_d        = werr_q;
        mem_we        = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    wid_d    = s_axi_awid;
                    waddr_d  = s_axi_awaddr[AddrTop-1:ByteLsb];
                    wlen_d   = s_axi_awlen;
                    wcnt_d   = '0;
                    werr_d   = aw_oor;
                    wstate_d = WData;
                end
            end
            WData: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_we  = !werr_q;
                    waddr_d = waddr_q + 1'b1;
                    wcnt_d  = wcnt_q + 4'd1;
                    // An early wlast closes the burst; no beat past awlen+1 is ever accepted.
                    if (s_axi_wlast || (wcnt_q == wlen_q)) begin
                        wstate_d = WResp;
                    end
                end
            end
            WResp: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    wstate_d = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    assign s_axi_bid   = wid_q;
    assign s_axi_bresp = werr_q ? 2'b11 : 2'b00;

    // RAM contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem_q[waddr_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- Read channel ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q <= RIdle;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rerr_q   <= rerr_d;
        end
    end

    // Read-first: a same-edge write to this word lands after the old value is sampled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
        end else if (rstate_q == RFetch) begin
            rdata_q <= rerr_q ? '0 : mem_q[raddr_q];
        end
    end

    always_comb begin
        rstate_d      = rstate_q;
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        rlen_d        = rlen_q;
        rcnt_d        = rcnt_q;
        rerr_d        = rerr_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        unique case (rstate_q)
            RIdle: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) begin
                    rid_d    = s_axi_arid;
                    raddr_d  = s_axi_araddr[AddrTop-1:ByteLsb];
                    rlen_d   = s_axi_arlen;
                    rcnt_d   = '0;
                    rerr_d   = ar_oor;
                    rstate_d = RFetch;
                end
            end
            RFetch: begin
                rstate_d = RData;
            end
            RData: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (rcnt_q == rlen_q);
                if (s_axi_rready) begin
                    if (rcnt_q == rlen_q) begin
                        rstate_d = RIdle;
                    end else begin
                        raddr_d  = raddr_q + 1'b1;
                        rcnt_d   = rcnt_q + 4'd1;
                        rstate_d = RFetch;
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    assign s_axi_rid   = rid_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rerr_q ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed bench for axi_ram_responder: bursts, strobes, wrap, back-pressure, read-first, reset.
// Expectations follow AXI_RAM_RESPONDER_RANGE_CHECK_EN the same way the RTL build does.
module tb_axi_ram_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;
    logic        awvalid, awready, arvalid, arready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, rvalid, rready, rlast;

    int total = 0;
    int bad   = 0;
    logic [63:0] rd_q[$];

    always #5 aclk = ~aclk;

    axi_ram_responder dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        int n = 0;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        while (!awready && n < 40) begin tick(); n++; end
        chk("awready_wait", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic last);
        int n = 0;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        while (!wready && n < 40) begin tick(); n++; end
        chk("wready_wait", wready, 1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [5:0] id, input logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 40) begin tick(); n++; end
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_bresp"}, bresp, resp);
        tick();
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        int n = 0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        while (!arready && n < 40) begin tick(); n++; end
        chk("arready_wait", arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        int n = 0;
        while (!rvalid && n < 40) begin tick(); n++; end
        chk({tag, "_rvalid"}, rvalid, 1);
    endtask

    // Reads a whole burst with rready held high into rd_q.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] resp);
        rd_q.delete();
        do_ar(addr, len, 6'd2);
        rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            wait_rvalid("rd");
            chk("rd_rresp", rresp, resp);
            rd_q.push_back(rdata);
            tick();
        end
        rready = 1'b0;
    endtask

    initial begin
        int cyc, beat, prev;
        logic [1:0]  oor_resp;
        logic [63:0] w0_exp;
`ifdef AXI_RAM_RESPONDER_RANGE_CHECK_EN
        oor_resp = 2'b11;
`else
        oor_resp = 2'b00;
`endif
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        tick();
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);

        // Four-beat write, response the cycle after wlast
        do_aw(32'h0, 4'd3, 6'd5);
        for (int i = 0; i < 4; i++) do_w(64'hA0 + 64'(i), 8'hFF, i == 3);
        chk("w4_bvalid_next", bvalid, 1);
        chk("w4_wready_off", wready, 0);
        do_b("w4", 6'd5, 2'b00);

        // Four-beat read, beats two cycles apart, rlast on the final one
        do_ar(32'h0, 4'd3, 6'd9);
        rready = 1'b1;
        cyc = 0; beat = 0; prev = 0;
        while (beat < 4 && cyc < 40) begin
            if (rvalid) begin
                chk("r4_data", rdata, 64'hA0 + 64'(beat));
                chk("r4_rid", rid, 9);
                chk("r4_rlast", rlast, beat == 3);
                if (beat > 0) chk("r4_spacing", 64'(cyc - prev), 2);
                prev = cyc;
                beat++;
            end
            tick();
            cyc++;
        end
        chk("r4_beats", 64'(beat), 4);
        rready = 1'b0;

        // Byte strobes
        do_aw(32'h38, 4'd0, 6'd1);
        do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        do_b("s1", 6'd1, 2'b00);
        do_aw(32'h38, 4'd0, 6'd2);
        do_w(64'h0, 8'h0F, 1'b1);
        do_b("s2", 6'd2, 2'b00);
        do_read(32'h38, 4'd0, 2'b00);
        chk("strb_word7", rd_q[0], 64'hFFFF_FFFF_0000_0000);

        // Index wrap from word 1022
        do_aw(32'h1FF0, 4'd3, 6'd3);
        for (int i = 0; i < 4; i++) do_w(64'(i + 1), 8'hFF, i == 3);
        do_b("wrap", 6'd3, 2'b00);
        do_read(32'h1FF0, 4'd3, 2'b00);
        for (int i = 0; i < 4; i++) chk("wrap_rd", rd_q[i], 64'(i + 1));

        // Early wlast, and no beat past awlen+1
        do_aw(32'h80, 4'd3, 6'd4);
        do_w(64'h11, 8'hFF, 1'b1);
        chk("early_bvalid", bvalid, 1);
        do_b("early", 6'd4, 2'b00);
        do_aw(32'h90, 4'd1, 6'd6);
        do_w(64'h21, 8'hFF, 1'b0);
        do_w(64'h22, 8'hFF, 1'b0);
        chk("cap_bvalid", bvalid, 1);
        chk("cap_wready", wready, 0);
        do_b("cap", 6'd6, 2'b00);
        do_read(32'h80, 4'd0, 2'b00);
        chk("early_word16", rd_q[0], 64'h11);
        do_read(32'h90, 4'd1, 2'b00);
        chk("cap_word18", rd_q[0], 64'h21);
        chk("cap_word19", rd_q[1], 64'h22);

        // bready back-pressure: response held, no new AW accepted
        do_aw(32'h28, 4'd0, 6'd12);
        do_w(64'h55, 8'hFF, 1'b1);
        awaddr = 32'h100; awlen = 4'd0; awid = 6'd13; awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bid", bid, 12);
            chk("bp_awready", awready, 0);
            tick();
        end
        awvalid = 1'b0;
        do_b("bp", 6'd12, 2'b00);

        // rready back-pressure on beat 2: words 0..3 now hold 3, 4, A2, A3
        do_ar(32'h0, 4'd3, 6'd7);
        rready = 1'b1;
        wait_rvalid("hold_b1");
        chk("hold_b1_data", rdata, 64'h3);
        tick();
        rready = 1'b0;
        wait_rvalid("hold_b2");
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, 64'h4);
            chk("hold_rlast", rlast, 0);
            chk("hold_rid", rid, 7);
            tick();
        end
        rready = 1'b1;
        tick();
        wait_rvalid("hold_b3");
        chk("hold_b3_data", rdata, 64'hA2);
        tick();
        wait_rvalid("hold_b4");
        chk("hold_b4_data", rdata, 64'hA3);
        chk("hold_b4_rlast", rlast, 1);
        tick();
        rready = 1'b0;
        chk("hold_done", rvalid, 0);

        // Same-cycle read and write of word 5 returns the old value
        do_aw(32'h28, 4'd0, 6'd1);
        do_w(64'h5555, 8'hFF, 1'b1);
        do_b("rf0", 6'd1, 2'b00);
        awaddr = 32'h28; awlen = 4'd0; awid = 6'd14; awvalid = 1'b1;
        araddr = 32'h28; arlen = 4'd0; arid = 6'd15; arvalid = 1'b1;
        wdata = 64'h6666; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("rf_rvalid", rvalid, 1);
        chk("rf_old_data", rdata, 64'h5555);
        chk("rf_bvalid", bvalid, 1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        do_b("rf", 6'd14, 2'b00);
        do_read(32'h28, 4'd0, 2'b00);
        chk("rf_new_data", rd_q[0], 64'h6666);

        // Upper address bits: alias onto word 0, or rejected when range checking
        do_aw(32'h0001_0000, 4'd0, 6'd8);
        do_w(64'hDEAD, 8'hFF, 1'b1);
        do_b("oor", 6'd8, oor_resp);
        w0_exp = (oor_resp == 2'b11) ? 64'h3 : 64'hDEAD;
        do_read(32'h0, 4'd0, 2'b00);
        chk("oor_word0", rd_q[0], w0_exp);
        do_read(32'h0001_0000, 4'd0, oor_resp);
        chk("oor_rdata", rd_q[0], (oor_resp == 2'b11) ? 64'h0 : w0_exp);

        // Reset mid-read aborts the burst; RAM survives
        do_ar(32'h0, 4'd3, 6'd10);
        wait_rvalid("mrst");
        aresetn = 1'b0;
        #1;
        chk("mrst_rvalid", rvalid, 0);
        chk("mrst_rdata", rdata, 0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("mrst_arready", arready, 1);
        chk("mrst_awready", awready, 1);
        chk("mrst_rvalid_after", rvalid, 0);
        do_read(32'h10, 4'd0, 2'b00);
        chk("mrst_ram_kept", rd_q[0], 64'hA2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
